sd_crc_engine: RTL and testbench
================================

# sd_crc_engine

Streaming SD-bus CRC engine for the RK8E Secure Digital interface. It sits between the SD byte shifter and the sector buffer. In generate mode it forwards a block of bytes and appends the CRC. In check mode it forwards the data bytes, consumes the trailing CRC bytes and reports pass/fail. One instance with CRC_W=7 serves command frames; one with CRC_W=16 serves 512-byte data blocks.

## Interface
- CRC_W, 16, CRC width; legal values 7 or 16 only.
- POLY, 16'h1021, generator polynomial without the x^CRC_W term. Use 7'h09 for CRC7.
- LEN_W, 10, width of the byte-count input. Maximum block is 2^LEN_W-1 bytes.
- clk  in  1  system clock; single clock domain.
- reset  in  1  synchronous, active-high.
- start  in  1  begin a block; sampled only in IDLE.
- mode  in  1  0 = generate, 1 = check; sampled with start.
- len  in  LEN_W  number of data bytes, excluding CRC bytes; sampled with start.
- abort  in  1  terminate the current block.
- s_valid / s_ready / s_data  in / out / [0:7]  input byte stream. Bit [0] is the MSB and is first on the wire.
- m_valid / m_ready / m_data  out / in / [0:7]  output byte stream.
- busy  out  1  high in any state other than IDLE.
- done  out  1  one-cycle pulse at the end of a block.
- crc_ok  out  1  check-mode result; held until the next start.
- crc_out  out  [0:CRC_W-1]  final computed CRC; held until the next start.

## Operation
- Bit order and arithmetic:
  - CRC is MSB-first with init value 0.
  - Each accepted data byte applies 8 serial steps: fb = crc[0] ^ d[i]; crc = {crc[1:], 0} ^ (fb ? POLY : 0).
- Number of CRC bytes, NCRC: 1 when CRC_W=7, 2 when CRC_W=16.
  - The CRC7 byte on the wire is {crc[0:6], 1'b1}.
  - CRC16 is sent as crc[0:7] then crc[8:15].
- States: IDLE -> DATA -> CRC -> IDLE.
- IDLE:
  - start latches mode and len, clears crc and the byte counter.
  - Goes to DATA, or straight to CRC if len==0.
- DATA:
  - Pass-through: m_valid=s_valid, s_ready=m_ready, m_data=s_data.
  - On each handshake (s_valid&s_ready): update crc, increment the counter.
  - After the len-th handshake, go to CRC.
- CRC in generate mode:
  - s_ready=0, m_valid=1, m_data = CRC byte k.
  - Advance k on m_ready; after the last byte, go to IDLE and pulse done.
- CRC in check mode:
  - m_valid=0, s_ready=1; each s_valid byte is compared with expected byte k.
  - For CRC7, a received end bit of 0 is a mismatch.
  - After NCRC bytes: crc_ok = no mismatch; go to IDLE and pulse done.
- crc_out holds the computed CRC in both modes.
- Boundary conditions:
  - start while busy is ignored.
  - abort in any non-IDLE state: IDLE on the next edge, no done, crc_ok=0.
  - abort has priority over a same-cycle handshake; the handshake does not update crc.
  - reset mid-block behaves like abort and also clears the outputs.
  - The byte counter never wraps; len is bounded by LEN_W.

## Timing
- Reset values: s_ready=0, m_valid=0, busy=0, done=0, crc_ok=0, crc_out=0, state=IDLE.
- The start cycle is not a transfer cycle; DATA begins on the next cycle.
- Zero added latency in DATA (combinational pass-through). Sustained 1 byte/clk when both sides are ready.
- crc is registered; a handshake at edge n is reflected in crc after edge n.
- done asserts the cycle after the final CRC-byte handshake. busy drops in the same cycle; crc_ok and crc_out are valid in that cycle.
- The earliest next start is the cycle done is high.
- Block time with no stalls: 1 + len + NCRC cycles.

## Structure
- Shared constants go in the shared SD type package: sdCRCMODE_t (sdcrcGEN, sdcrcCHK), sdCRCSTATE_t (IDLE/DATA/CRC), SD_CRC7_POLY=7'h09, SD_CRC16_POLY=16'h1021.
- Sub-module sd_crc_step: combinational byte update parametrised by CRC_W and POLY.
- The existing crc7/crc16 package functions stay as golden models for the bench.
- The FSM, counter and output muxing live in sd_crc_engine.

## Test plan
- CRC_W=7, gen, len=5, input 40 00 00 00 00 -> output 40 00 00 00 00 95; crc_out=7'h4A; done pulses once.
- CRC_W=7, gen, input 48 00 00 01 AA -> appended byte 87; then the same frame in check mode with trailing 87 -> crc_ok=1. With trailing 86 (end bit 0) -> crc_ok=0.
- CRC_W=16, gen, ASCII "123456789" -> crc_out=16'h31C3, trailing bytes 31 C3. The same run with random s_valid/m_ready stalls gives an identical byte stream.
- CRC_W=16, check, 512×FF followed by 7F A1 -> crc_ok=1. Trailing 7F A0 -> crc_ok=0. Throughput 515 cycles with no stalls.
- len=0 in gen mode -> CRC7 emits 01 and CRC16 emits 00 00; done follows.
- abort after 100 bytes, and separately reset after 100 bytes -> IDLE next cycle, no done, crc_ok=0. A following start works normally; start pulses while busy have no effect.

Source files
------------

// File: rtl/sd_crc_engine_pkg.sv
// Shared SD CRC types and constants; crc7/crc16 are bit-serial byte updates
// (MSB of the byte first) for anyone wanting a software reference.
package sd_crc_engine_pkg;

    typedef enum logic {
        sdcrcGEN = 1'b0,
        sdcrcCHK = 1'b1
    } sdCRCMODE_t;

    typedef enum logic [1:0] {
        sdcrcIDLE = 2'd0,
        sdcrcDATA = 2'd1,
        sdcrcCRC  = 2'd2
    } sdCRCSTATE_t;

    localparam logic [6:0]  SD_CRC7_POLY  = 7'h09;
    localparam logic [15:0] SD_CRC16_POLY = 16'h1021;

    function automatic logic [6:0] crc7(input logic [6:0] crc, input logic [7:0] d);
        logic [6:0] c;
        logic       fb;
        c = crc;
        for (int i = 7; i >= 0; i--) begin
            fb = c[6] ^ d[i];
            c  = {c[5:0], 1'b0} ^ (fb ? SD_CRC7_POLY : 7'h00);
        end
        return c;
    endfunction

    function automatic logic [15:0] crc16(input logic [15:0] crc, input logic [7:0] d);
        logic [15:0] c;
        logic        fb;
        c = crc;
        for (int i = 7; i >= 0; i--) begin
            fb = c[15] ^ d[i];
            c  = {c[14:0], 1'b0} ^ (fb ? SD_CRC16_POLY : 16'h0000);
        end
        return c;
    endfunction

endpackage

// File: rtl/sd_crc_engine_if.sv
// Control, byte-stream and result signals of one SD CRC engine.
// The engine side uses the slave modport.
interface sd_crc_engine_if #(
    parameter int CRC_W = 16,
    parameter int LEN_W = 10
) ();
    logic             start;
    logic             mode;
    logic [LEN_W-1:0] len;
    logic             abort;
    logic             s_valid;
    logic             s_ready;
    logic [0:7]       s_data;
    logic             m_valid;
    logic             m_ready;
    logic [0:7]       m_data;
    logic             busy;
    logic             done;
    logic             crc_ok;
    logic [0:CRC_W-1] crc_out;

    modport master (
        output start, mode, len, abort, s_valid, s_data, m_ready,
        input  s_ready, m_valid, m_data, busy, done, crc_ok, crc_out
    );

    modport slave (
        input  start, mode, len, abort, s_valid, s_data, m_ready,
        output s_ready, m_valid, m_data, busy, done, crc_ok, crc_out
    );
endinterface

// File: rtl/sd_crc_step.sv
// One byte of MSB-first CRC update (8 serial steps, index 0 = MSB).
module sd_crc_step #(
    parameter int               CRC_W = 16,
    parameter logic [CRC_W-1:0] POLY  = '0
) (
    input  logic [0:CRC_W-1] crc_in,
    input  logic [0:7]       data,
    output logic [0:CRC_W-1] crc_out
);
    logic [0:CRC_W-1] poly_v;

    assign poly_v = POLY;

    always_comb begin : step_blk
        logic [0:CRC_W-1] c;
        logic             fb;
        c  = crc_in;
        fb = 1'b0;
        for (int i = 0; i < 8; i++) begin
            fb = c[0] ^ data[i];
            c  = {c[1:CRC_W-1], 1'b0} ^ (fb ? poly_v : '0);
        end
        crc_out = c;
    end
endmodule

// File: rtl/sd_crc_engine.sv
// Streaming SD CRC engine: forwards a block of bytes, then either appends
// the CRC (generate) or consumes and checks the trailing CRC bytes (check).
module sd_crc_engine
    import sd_crc_engine_pkg::*;
#(
    parameter int          CRC_W = 16,
    parameter logic [15:0] POLY  = SD_CRC16_POLY,
    parameter int          LEN_W = 10
) (
    input logic            clk,
    input logic            reset,
    sd_crc_engine_if.slave bus
);
    localparam int   NCRC   = (CRC_W == 7) ? 1 : 2;
    localparam logic K_LAST = (NCRC == 2);

    sdCRCSTATE_t      state_q, state_d;
    sdCRCMODE_t       mode_q, mode_d;
    logic [LEN_W-1:0] len_q, len_d;
    logic [LEN_W-1:0] cnt_q, cnt_d;
    logic [0:CRC_W-1] crc_q, crc_d;
    logic [0:CRC_W-1] crc_step;
    logic             k_q, k_d;
    logic             mism_q, mism_d;
    logic             done_q, done_d;
    logic             crc_ok_q, crc_ok_d;
    logic [0:15]      crc_wire;
    logic [0:7]       crc_byte;
    logic             mism_next;
    logic             crc_hs;

    sd_crc_step #(
        .CRC_W (CRC_W),
        .POLY  (POLY[CRC_W-1:0])
    ) u_step (
        .crc_in  (crc_q),
        .data    (bus.s_data),
        .crc_out (crc_step)
    );

    // Wire image of the CRC: CRC7 carries its end bit in the low bit of byte 0.
    always_comb begin
        crc_wire            = '0;
        crc_wire[0:CRC_W-1] = crc_q;
        if (CRC_W == 7) begin
            crc_wire[7] = 1'b1;
        end
    end

    assign crc_byte  = k_q ? crc_wire[8:15] : crc_wire[0:7];
    assign mism_next = mism_q | (bus.s_data != crc_byte);
    assign crc_hs    = (mode_q == sdcrcGEN) ? bus.m_ready : bus.s_valid;

    always_comb begin
        state_d     = state_q;
        mode_d      = mode_q;
        len_d       = len_q;
        cnt_d       = cnt_q;
        crc_d       = crc_q;
        k_d         = k_q;
        mism_d      = mism_q;
        done_d      = 1'b0;
        crc_ok_d    = crc_ok_q;
        bus.s_ready = 1'b0;
        bus.m_valid = 1'b0;
        bus.m_data  = '0;

        unique case (state_q)
            sdcrcIDLE: begin
                if (bus.start) begin
                    mode_d   = sdCRCMODE_t'(bus.mode);
                    len_d    = bus.len;
                    cnt_d    = '0;
                    crc_d    = '0;
                    k_d      = 1'b0;
                    mism_d   = 1'b0;
                    crc_ok_d = 1'b0;
                    state_d  = (bus.len == '0) ? sdcrcCRC : sdcrcDATA;
                end
            end

            sdcrcDATA: begin
                bus.m_valid = bus.s_valid;
                bus.s_ready = bus.m_ready;
                bus.m_data  = bus.s_data;
                if (bus.abort) begin
                    state_d  = sdcrcIDLE;
                    crc_ok_d = 1'b0;
                end else if (bus.s_valid && bus.m_ready) begin
                    crc_d = crc_step;
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == len_q - 1'b1) begin
                        state_d = sdcrcCRC;
                        k_d     = 1'b0;
                    end
                end
            end

            sdcrcCRC: begin
                if (mode_q == sdcrcGEN) begin
                    bus.m_valid = 1'b1;
                    bus.m_data  = crc_byte;
                end else begin
                    bus.s_ready = 1'b1;
                end
                if (bus.abort) begin
                    state_d  = sdcrcIDLE;
                    crc_ok_d = 1'b0;
                end else if (crc_hs) begin
                    if (mode_q == sdcrcCHK) begin
                        mism_d = mism_next;
                    end
                    if (k_q == K_LAST) begin
                        state_d  = sdcrcIDLE;
                        done_d   = 1'b1;
                        crc_ok_d = (mode_q == sdcrcCHK) && !mism_next;
                    end else begin
                        k_d = 1'b1;
                    end
                end
            end

            default: begin
                state_d = sdcrcIDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= sdcrcIDLE;
            mode_q   <= sdcrcGEN;
            len_q    <= '0;
            cnt_q    <= '0;
            crc_q    <= '0;
            k_q      <= 1'b0;
            mism_q   <= 1'b0;
            done_q   <= 1'b0;
            crc_ok_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            mode_q   <= mode_d;
            len_q    <= len_d;
            cnt_q    <= cnt_d;
            crc_q    <= crc_d;
            k_q      <= k_d;
            mism_q   <= mism_d;
            done_q   <= done_d;
            crc_ok_q <= crc_ok_d;
        end
    end

    assign bus.busy    = (state_q != sdcrcIDLE);
    assign bus.done    = done_q;
    assign bus.crc_ok  = crc_ok_q;
    assign bus.crc_out = crc_q;
endmodule

// File: tb/tb_sd_crc_engine.sv
// Bench for sd_crc_engine: one CRC7 and one CRC16 instance, directed frames
// plus random blocks checked against a polynomial long-division model.
module tb_sd_crc_engine;
    import sd_crc_engine_pkg::*;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    sd_crc_engine_if #(.CRC_W(7),  .LEN_W(10)) if7 ();
    sd_crc_engine_if #(.CRC_W(16), .LEN_W(10)) if16 ();

    sd_crc_engine #(.CRC_W(7), .POLY(16'h0009), .LEN_W(10)) u_crc7 (
        .clk(clk), .reset(rst), .bus(if7)
    );
    sd_crc_engine #(.CRC_W(16), .POLY(16'h1021), .LEN_W(10)) u_crc16 (
        .clk(clk), .reset(rst), .bus(if16)
    );

    logic       sel, start, mode, abort, s_valid, m_ready;
    logic [9:0] len;
    logic [7:0] s_data;

    assign if7.start    = start & ~sel;
    assign if16.start   = start & sel;
    assign if7.abort    = abort & ~sel;
    assign if16.abort   = abort & sel;
    assign if7.mode     = mode;
    assign if16.mode    = mode;
    assign if7.len      = len;
    assign if16.len     = len;
    assign if7.s_valid  = s_valid;
    assign if16.s_valid = s_valid;
    assign if7.s_data   = s_data;
    assign if16.s_data  = s_data;
    assign if7.m_ready  = m_ready;
    assign if16.m_ready = m_ready;

    logic        o_s_ready, o_m_valid, o_busy, o_done, o_crc_ok;
    logic [7:0]  o_m_data;
    logic [15:0] o_crc;
    assign o_s_ready = sel ? if16.s_ready : if7.s_ready;
    assign o_m_valid = sel ? if16.m_valid : if7.m_valid;
    assign o_m_data  = sel ? if16.m_data  : if7.m_data;
    assign o_busy    = sel ? if16.busy    : if7.busy;
    assign o_done    = sel ? if16.done    : if7.done;
    assign o_crc_ok  = sel ? if16.crc_ok  : if7.crc_ok;
    assign o_crc     = sel ? if16.crc_out : {9'd0, if7.crc_out};

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    endtask

    logic [7:0] blk [0:1023];
    logic [7:0] tail [0:1];
    logic [7:0] out_q[$];
    logic [7:0] ref_q[$];
    int          r_cyc;
    logic        r_ok;
    logic [15:0] r_crc;

    // Remainder of M(x)*x^W divided by the full generator, done bit by bit.
    function automatic int ref_crc(input bit w16, input int n);
        int w = w16 ? 16 : 7;
        int g = w16 ? 'h11021 : 'h89;
        int r = 0;
        for (int i = 0; i < n * 8 + w; i++) begin
            int b;
            b = (i < n * 8) ? int'(blk[i / 8][7 - (i % 8)]) : 0;
            r = (r << 1) | b;
            if (((r >> w) & 1) == 1) r = r ^ g;
        end
        return r;
    endfunction

    function automatic logic [7:0] exp_byte(input bit w16, input int r, input int k);
        if (w16) return (k == 0) ? 8'(r >> 8) : 8'(r);
        return {r[6:0], 1'b1};
    endfunction

    function automatic int n_diff(input logic [7:0] a[$], input logic [7:0] b[$]);
        int d = 0;
        for (int i = 0; i < a.size() && i < b.size(); i++)
            if (a[i] !== b[i]) d++;
        return d;
    endfunction

    // Runs one block; cut >= 0 interrupts it (abort or reset) after cut bytes.
    task automatic run_block(input string tag, input bit w16, input bit md, input int n,
                             input bit stall, input int cut, input bit cut_rst);
        int   ncrc = w16 ? 2 : 1;
        int   idx = 0;
        int   t_s;
        int   r;
        int   seen;
        bit   fin = 0;
        bit   ok_exp;
        logic [7:0] exp_q[$];
        out_q.delete();
        @(negedge clk);
        sel = w16; start = 1'b1; mode = md; len = n[9:0];
        s_valid = 1'b0; m_ready = 1'b0; abort = 1'b0;
        t_s = cyc;
        for (int b = 0; b < 5000 && !fin; b++) begin
            @(negedge clk);
            start = stall && o_busy && ($urandom_range(0, 5) == 0);
            if (start) begin
                mode = 1'($urandom_range(0, 1));
                len  = 10'($urandom);
            end
            s_valid = (idx < n + (md ? ncrc : 0)) && (!stall || $urandom_range(0, 3) != 0);
            s_data  = !s_valid ? 8'($urandom) : (idx < n) ? blk[idx] : tail[idx - n];
            m_ready = !stall || ($urandom_range(0, 2) != 0);
            if (idx == cut) begin
                s_valid = 1'b1; s_data = blk[idx]; m_ready = 1'b1;
                if (cut_rst) rst = 1'b1;
                else abort = 1'b1;
            end
            #1;
            if (o_done) begin
                r_cyc = cyc - t_s; r_ok = o_crc_ok; r_crc = o_crc; fin = 1;
            end else if (idx == cut) begin
                @(negedge clk);
                rst = 1'b0; abort = 1'b0; s_valid = 1'b0; m_ready = 1'b0;
                #1;
                chk({tag, "_busy"}, 32'(o_busy), 0);
                chk({tag, "_crc_ok"}, 32'(o_crc_ok), 0);
                chk({tag, "_crc_out"}, 32'(o_crc), cut_rst ? 0 : ref_crc(w16, cut));
                seen = 0;
                repeat (4) begin
                    @(negedge clk); #1;
                    if (o_done) seen++;
                end
                chk({tag, "_no_done"}, 32'(seen), 0);
                fin = 1;
                cut = -2;
            end else begin
                if (s_valid && o_s_ready) idx++;
                if (o_m_valid && m_ready) out_q.push_back(o_m_data);
            end
        end
        start = 1'b0; s_valid = 1'b0; m_ready = 1'b0;
        if (!fin) chk({tag, "_timeout"}, 0, 1);
        if (fin && cut != -2) begin
            r = ref_crc(w16, n);
            for (int i = 0; i < n; i++) exp_q.push_back(blk[i]);
            ok_exp = md;
            for (int k = 0; k < ncrc; k++) begin
                if (!md) exp_q.push_back(exp_byte(w16, r, k));
                if (tail[k] !== exp_byte(w16, r, k)) ok_exp = 0;
            end
            chk({tag, "_nbytes"}, 32'(out_q.size()), 32'(exp_q.size()));
            chk({tag, "_bytes"}, 32'(n_diff(out_q, exp_q)), 0);
            chk({tag, "_crc"}, 32'(r_crc), 32'(r));
            chk({tag, "_ok"}, 32'(r_ok), 32'(ok_exp));
            if (!stall) chk({tag, "_cycles"}, 32'(r_cyc), 32'(1 + n + ncrc));
            @(negedge clk); #1;
            chk({tag, "_done_pulse"}, 32'(o_done), 0);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int r;
        rst = 1'b1; sel = 1'b1; start = 1'b0; mode = 1'b0; len = '0;
        abort = 1'b0; s_valid = 1'b0; s_data = '0; m_ready = 1'b0;
        tail[0] = 8'h00; tail[1] = 8'h00;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rst_busy", 32'(o_busy), 0);
        chk("rst_done", 32'(o_done), 0);
        chk("rst_crc_ok", 32'(o_crc_ok), 0);
        chk("rst_crc_out", 32'(o_crc), 0);
        chk("rst_s_ready", 32'(o_s_ready), 0);
        chk("rst_m_valid", 32'(o_m_valid), 0);
        chk("rst_busy7", 32'(if7.busy), 0);
        chk("rst_crc7", 32'(if7.crc_out), 0);

        blk[0] = 8'h40; blk[1] = 8'h00; blk[2] = 8'h00; blk[3] = 8'h00; blk[4] = 8'h00;
        run_block("c7_cmd0", 0, 0, 5, 0, -1, 0);
        chk("c7_cmd0_crcbyte", 32'(out_q[5]), 'h95);
        chk("c7_cmd0_crcval", 32'(r_crc), 'h4A);

        blk[0] = 8'h48; blk[1] = 8'h00; blk[2] = 8'h00; blk[3] = 8'h01; blk[4] = 8'hAA;
        run_block("c7_cmd8", 0, 0, 5, 0, -1, 0);
        chk("c7_cmd8_crcbyte", 32'(out_q[5]), 'h87);
        tail[0] = 8'h87;
        run_block("c7_cmd8_chk", 0, 1, 5, 0, -1, 0);
        chk("c7_cmd8_pass", 32'(r_ok), 1);
        tail[0] = 8'h86;
        run_block("c7_cmd8_bad", 0, 1, 5, 0, -1, 0);
        chk("c7_cmd8_endbit", 32'(r_ok), 0);

        for (int i = 0; i < 9; i++) blk[i] = 8'h31 + 8'(i);
        run_block("c16_ascii", 1, 0, 9, 0, -1, 0);
        chk("c16_ascii_crcval", 32'(r_crc), 'h31C3);
        chk("c16_ascii_hi", 32'(out_q[9]), 'h31);
        chk("c16_ascii_lo", 32'(out_q[10]), 'hC3);
        ref_q = out_q;
        run_block("c16_ascii_stall", 1, 0, 9, 1, -1, 0);
        chk("c16_stall_same", 32'(n_diff(out_q, ref_q)), 0);

        for (int i = 0; i < 512; i++) blk[i] = 8'hFF;
        tail[0] = 8'h7F; tail[1] = 8'hA1;
        run_block("c16_ff512", 1, 1, 512, 0, -1, 0);
        chk("c16_ff512_pass", 32'(r_ok), 1);
        chk("c16_ff512_time", 32'(r_cyc), 515);
        tail[1] = 8'hA0;
        run_block("c16_ff512_bad", 1, 1, 512, 0, -1, 0);
        chk("c16_ff512_fail", 32'(r_ok), 0);

        run_block("c7_len0", 0, 0, 0, 0, -1, 0);
        chk("c7_len0_byte", 32'(out_q[0]), 'h01);
        run_block("c16_len0", 1, 0, 0, 0, -1, 0);
        chk("c16_len0_n", 32'(out_q.size()), 2);
        chk("c16_len0_bytes", 32'({out_q[0], out_q[1]}), 0);

        for (int i = 0; i < 200; i++) blk[i] = 8'($urandom);
        run_block("abort100", 1, 0, 150, 0, 100, 0);
        run_block("reset100", 1, 1, 150, 0, 100, 1);
        run_block("after_cut", 1, 0, 150, 1, -1, 0);

        for (int t = 0; t < 14; t++) begin
            bit w16, md, st;
            int n, nc;
            w16 = 1'($urandom_range(0, 1));
            md  = 1'($urandom_range(0, 1));
            st  = 1'($urandom_range(0, 1));
            n   = ($urandom_range(0, 4) == 0) ? $urandom_range(100, 300) : $urandom_range(0, 40);
            nc  = w16 ? 2 : 1;
            for (int i = 0; i < n; i++) blk[i] = 8'($urandom);
            r = ref_crc(w16, n);
            for (int k = 0; k < nc; k++) tail[k] = exp_byte(w16, r, k);
            if ($urandom_range(0, 1) == 1) begin
                int k;
                k = $urandom_range(0, nc - 1);
                tail[k] = tail[k] ^ (8'h01 << $urandom_range(0, 7));
            end
            run_block($sformatf("rand%0d", t), w16, md, n, st, -1, 0);
        end

        for (int i = 0; i < 1023; i++) blk[i] = 8'($urandom);
        run_block("c16_maxlen", 1, 0, 1023, 0, -1, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
